hex_scroll_ctrl: RTL and testbench

- Scroll scheduler for the eight-digit seven-segment bank HEX7..HEX0.
- Holds a writable message buffer of character codes and divides CLOCK_50 into step ticks.
- Sequences a rotating window of the buffer onto the eight digits, with run/pause, direction and end-of-message hold control.
- Sits between board-level control inputs (switches/keys) and the HEX outputs. It replaces hard-wired per-digit decode tables with one scheduled datapath.

---
 rtl/hex_scroll_if.sv | 30 +++
 rtl/hex_scroll_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hex_scroll_if.sv
// Control and display bundle between board-level inputs and the scroll controller.
// The master side drives run/direction/length and buffer writes; the slave returns HEX, POS and WRAP.
interface hex_scroll_if;
   logic       RUN;
   logic       DIR;
   logic [4:0] LEN;
   logic       WE;
   logic [3:0] WADDR;
   logic [2:0] WDATA;
   logic [0:6] HEX7;
   logic [0:6] HEX6;
   logic [0:6] HEX5;
   logic [0:6] HEX4;
   logic [0:6] HEX3;
   logic [0:6] HEX2;
   logic [0:6] HEX1;
   logic [0:6] HEX0;
   logic [3:0] POS;
   logic       WRAP;

   modport master (
      output RUN, DIR, LEN, WE, WADDR, WDATA,
      input  HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, POS, WRAP
   );

   modport slave (
      input  RUN, DIR, LEN, WE, WADDR, WDATA,
      output HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, POS, WRAP
   );
endinterface

// File: rtl/hex_scroll_ctrl.sv
// Scroll scheduler: rotates a window of a 16-entry character buffer across HEX7..HEX0.
// Optional macro HEX_SCROLL_BLINK_EN blanks the display for the first half of each step while holding.
module hex_scroll_ctrl #(
   parameter int TICK_DIV   = 50000000,
   parameter int MSG_MAX    = 16,
   parameter int HOLD_TICKS = 0
) (
   input logic         CLOCK_50,
   input logic         Resetn,
   hex_scroll_if.slave bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);
`ifdef HEX_SCROLL_BLINK_EN
   localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2);
`endif

   typedef enum logic [1:0] {STOP, SCROLL, HOLD} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    pos_q, pos_d;
   logic [4:0]    len_q, len_d;
   logic [3:0]    hold_q, hold_d;
   logic          wrap_q, wrap_d;
   logic          step;
   logic [4:0]    len_new;
   logic [4:0]    pos_inc;
   logic [3:0]    pos_step;

   logic [2:0]    msg_buf [MSG_MAX];
   logic [0:6]    hex_d [8];
   logic [0:6]    hex_q [8];

   function automatic logic [0:6] seg_of(input logic [2:0] code);
      case (code)
         3'd1:    seg_of = 7'b1001000;
         3'd2:    seg_of = 7'b0110000;
         3'd3:    seg_of = 7'b1110001;
         3'd4:    seg_of = 7'b0000001;
         default: seg_of = 7'b1111111;
      endcase
   endfunction

   // Window index wraps with a true modulo so any length 1..16 tiles the eight digits.
   function automatic logic [3:0] win_idx(input logic [3:0] pos, input logic [2:0] k,
                                          input logic [4:0] len);
      logic [4:0] sum;
      sum = {1'b0, pos} + {2'b00, k};
      return 4'(sum % len);
   endfunction

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= STOP;
         presc_q <= '0;
         pos_q   <= 4'd0;
         len_q   <= 5'd8;
         hold_q  <= 4'd0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         pos_q   <= pos_d;
         len_q   <= len_d;
         hold_q  <= hold_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      pos_d    = pos_q;
      len_d    = len_q;
      hold_d   = hold_q;
      wrap_d   = 1'b0;
      step     = (state_q != STOP) && (presc_q == TERM);
      len_new  = (bus.LEN == 5'd0 || bus.LEN > 5'(MSG_MAX)) ? 5'(MSG_MAX) : bus.LEN;
      pos_inc  = {1'b0, pos_q} + 5'd1;
      if (bus.DIR)
         pos_step = (pos_q == 4'd0) ? 4'(len_q - 5'd1) : pos_q - 4'd1;
      else
         pos_step = (pos_inc == len_q) ? 4'd0 : pos_inc[3:0];

      case (state_q)
         STOP: begin
            presc_d = '0;
            hold_d  = 4'd0;
            if (bus.RUN) begin
               len_d = len_new;
               if ({1'b0, pos_q} >= len_new)
                  pos_d = 4'd0;
               state_d = SCROLL;
            end
         end
         SCROLL: begin
            if (!bus.RUN) begin
               state_d = STOP;
               presc_d = '0;
               hold_d  = 4'd0;
            end else begin
               presc_d = step ? '0 : presc_q + PW'(1);
               if (step) begin
                  pos_d = pos_step;
                  if (pos_step == 4'd0) begin
                     wrap_d = 1'b1;
                     if (HOLD_TICKS > 0) begin
                        state_d = HOLD;
                        hold_d  = 4'(HOLD_TICKS);
                     end
                  end
               end
            end
         end
         HOLD: begin
            if (!bus.RUN) begin
               state_d = STOP;
               presc_d = '0;
               hold_d  = 4'd0;
            end else begin
               presc_d = step ? '0 : presc_q + PW'(1);
               // The step that empties the counter only releases the hold; POS moves on the next one.
               if (step) begin
                  hold_d = hold_q - 4'd1;
                  if (hold_q <= 4'd1)
                     state_d = SCROLL;
               end
            end
         end
         default: state_d = STOP;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < MSG_MAX; i++)
            msg_buf[i] <= 3'd0;
         msg_buf[0] <= 3'd1;
         msg_buf[1] <= 3'd2;
         msg_buf[2] <= 3'd3;
         msg_buf[3] <= 3'd3;
         msg_buf[4] <= 3'd4;
      end else if (bus.WE) begin
         msg_buf[bus.WADDR] <= bus.WDATA;
      end
   end

   // Digit k of the window drives HEX(7-k).
   always_comb begin
      for (int k = 0; k < 8; k++)
         hex_d[k] = seg_of(msg_buf[win_idx(pos_q, 3'(k), len_q)]);
`ifdef HEX_SCROLL_BLINK_EN
      if (state_q == HOLD && presc_q < HALF)
         for (int k = 0; k < 8; k++)
            hex_d[k] = 7'b1111111;
`endif
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         for (int k = 0; k < 8; k++)
            hex_q[k] <= 7'b1111111;
      end else begin
         for (int k = 0; k < 8; k++)
            hex_q[k] <= hex_d[k];
      end
   end

   assign bus.HEX7 = hex_q[0];
   assign bus.HEX6 = hex_q[1];
   assign bus.HEX5 = hex_q[2];
   assign bus.HEX4 = hex_q[3];
   assign bus.HEX3 = hex_q[4];
   assign bus.HEX2 = hex_q[5];
   assign bus.HEX1 = hex_q[6];
   assign bus.HEX0 = hex_q[7];
   assign bus.POS  = pos_q;
   assign bus.WRAP = wrap_q;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with TICK_DIV=4: table of scroll vectors plus
// hand sequences for reset, writes, length clamping, pause priority, L=1 and the hold window.
module tb_hex_scroll_ctrl;

   typedef logic [55:0] hexv_t;

   localparam logic [0:6] C_B = 7'b1111111;
   localparam logic [0:6] C_H = 7'b1001000;
   localparam logic [0:6] C_E = 7'b0110000;
   localparam logic [0:6] C_L = 7'b1110001;
   localparam logic [0:6] C_O = 7'b0000001;

   localparam hexv_t W_ALLB = {C_B, C_B, C_B, C_B, C_B, C_B, C_B, C_B};
   localparam hexv_t W0     = {C_H, C_E, C_L, C_L, C_O, C_B, C_B, C_B};
   localparam hexv_t W1     = {C_E, C_L, C_L, C_O, C_B, C_B, C_B, C_H};
   localparam hexv_t W2     = {C_L, C_L, C_O, C_B, C_B, C_B, C_H, C_E};
   localparam hexv_t W3     = {C_L, C_O, C_B, C_B, C_B, C_H, C_E, C_L};
   localparam hexv_t W4     = {C_O, C_B, C_B, C_B, C_H, C_E, C_L, C_L};
   localparam hexv_t W6     = {C_B, C_B, C_H, C_E, C_L, C_L, C_O, C_B};
   localparam hexv_t W7     = {C_B, C_H, C_E, C_L, C_L, C_O, C_B, C_B};
   localparam hexv_t WL2_0  = {C_H, C_E, C_H, C_E, C_H, C_E, C_H, C_E};
   localparam hexv_t WL2_1  = {C_E, C_H, C_E, C_H, C_E, C_H, C_E, C_H};
   localparam hexv_t W_WR   = {C_H, C_E, C_L, C_L, C_O, C_H, C_B, C_B};
   localparam hexv_t W16_15 = {C_B, C_H, C_E, C_L, C_L, C_O, C_H, C_B};

   typedef struct {
      logic       run;
      logic       dir;
      logic [4:0] len;
      int         cycles;
      logic [3:0] pos;
      logic       wrap;
      hexv_t      hex;
   } vec_t;

   logic  CLOCK_50 = 1'b0;
   logic  Resetn   = 1'b1;
   int    checks   = 0;
   int    failures = 0;
   int    blanks;
   vec_t  vecs [20];
   hexv_t hex_a, hex_b;

   always #5 CLOCK_50 = ~CLOCK_50;

   hex_scroll_if bus_a();
   hex_scroll_if bus_b();

   hex_scroll_ctrl #(.TICK_DIV(4), .MSG_MAX(16), .HOLD_TICKS(0)) dut_a (
      .CLOCK_50(CLOCK_50), .Resetn(Resetn), .bus(bus_a)
   );

   hex_scroll_ctrl #(.TICK_DIV(4), .MSG_MAX(16), .HOLD_TICKS(2)) dut_b (
      .CLOCK_50(CLOCK_50), .Resetn(Resetn), .bus(bus_b)
   );

   assign hex_a = {bus_a.HEX7, bus_a.HEX6, bus_a.HEX5, bus_a.HEX4,
                   bus_a.HEX3, bus_a.HEX2, bus_a.HEX1, bus_a.HEX0};
   assign hex_b = {bus_b.HEX7, bus_b.HEX6, bus_b.HEX5, bus_b.HEX4,
                   bus_b.HEX3, bus_b.HEX2, bus_b.HEX1, bus_b.HEX0};

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus_a.RUN = v.run;
      bus_a.DIR = v.dir;
      bus_a.LEN = v.len;
      repeat (v.cycles) @(negedge CLOCK_50);
   endtask

   // Leaves the bench on a negedge with both DUTs stopped at POS=0.
   task automatic doReset(input string tag);
      Resetn = 1'b0;
      #1;
      checkOutput({tag, "_rst_hex"}, hex_a, W_ALLB);
      checkOutput({tag, "_rst_pos"}, bus_a.POS, 4'd0);
      checkOutput({tag, "_rst_wrap"}, bus_a.WRAP, 1'b0);
      @(negedge CLOCK_50);
      Resetn = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      checkOutput({tag, "_hello"}, hex_a, W0);
      checkOutput({tag, "_hello_pos"}, bus_a.POS, 4'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 5'd8, 4,  4'd0, 1'b0, W0};
      vecs[1]  = '{1'b1, 1'b0, 5'd8, 1,  4'd1, 1'b0, W0};
      vecs[2]  = '{1'b1, 1'b0, 5'd8, 1,  4'd1, 1'b0, W1};
      vecs[3]  = '{1'b1, 1'b0, 5'd8, 4,  4'd2, 1'b0, W2};
      vecs[4]  = '{1'b1, 1'b0, 5'd8, 22, 4'd7, 1'b0, W7};
      vecs[5]  = '{1'b1, 1'b0, 5'd8, 1,  4'd0, 1'b1, W7};
      vecs[6]  = '{1'b1, 1'b0, 5'd8, 1,  4'd0, 1'b0, W0};
      vecs[7]  = '{1'b1, 1'b1, 5'd8, 3,  4'd7, 1'b0, W0};
      vecs[8]  = '{1'b1, 1'b1, 5'd8, 1,  4'd7, 1'b0, W7};
      vecs[9]  = '{1'b1, 1'b1, 5'd8, 4,  4'd6, 1'b0, W6};
      vecs[10] = '{1'b1, 1'b1, 5'd8, 11, 4'd3, 1'b0, W4};
      vecs[11] = '{1'b0, 1'b0, 5'd8, 20, 4'd3, 1'b0, W3};
      vecs[12] = '{1'b1, 1'b0, 5'd8, 4,  4'd3, 1'b0, W3};
      vecs[13] = '{1'b1, 1'b0, 5'd8, 1,  4'd4, 1'b0, W3};
      vecs[14] = '{1'b1, 1'b1, 5'd8, 4,  4'd3, 1'b0, W4};
      vecs[15] = '{1'b0, 1'b1, 5'd8, 3,  4'd3, 1'b0, W3};
      vecs[16] = '{1'b1, 1'b0, 5'd2, 1,  4'd0, 1'b0, W3};
      vecs[17] = '{1'b1, 1'b0, 5'd2, 1,  4'd0, 1'b0, WL2_0};
      vecs[18] = '{1'b1, 1'b0, 5'd2, 3,  4'd1, 1'b0, WL2_0};
      vecs[19] = '{1'b1, 1'b0, 5'd2, 4,  4'd0, 1'b1, WL2_1};

      bus_a.RUN = 1'b0; bus_a.DIR = 1'b0; bus_a.LEN = 5'd8;
      bus_a.WE = 1'b0;  bus_a.WADDR = 4'd0; bus_a.WDATA = 3'd0;
      bus_b.RUN = 1'b0; bus_b.DIR = 1'b0; bus_b.LEN = 5'd8;
      bus_b.WE = 1'b0;  bus_b.WADDR = 4'd0; bus_b.WDATA = 3'd0;
      #2;
      doReset("init");

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d_pos", i), bus_a.POS, vecs[i].pos);
         checkOutput($sformatf("vec%0d_wrap", i), bus_a.WRAP, vecs[i].wrap);
         checkOutput($sformatf("vec%0d_hex", i), hex_a, vecs[i].hex);
      end

      // Reset while scrolling.
      bus_a.RUN = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      doReset("pre_mid");
      bus_a.RUN = 1'b1; bus_a.LEN = 5'd8; bus_a.DIR = 1'b0;
      repeat (9) @(negedge CLOCK_50);
      checkOutput("mid_scroll_pos", bus_a.POS, 4'd2);
      bus_a.RUN = 1'b0;
      doReset("mid");

      // Buffer write visible on the cycle after the write edge.
      bus_a.WE = 1'b1; bus_a.WADDR = 4'd5; bus_a.WDATA = 3'd1;
      @(negedge CLOCK_50);
      bus_a.WE = 1'b0;
      checkOutput("write_latency", hex_a, W0);
      @(negedge CLOCK_50);
      checkOutput("write_visible", hex_a, W_WR);

      // LEN=0 clamps to 16: wrap after sixteen steps.
      bus_a.LEN = 5'd0; bus_a.RUN = 1'b1; bus_a.DIR = 1'b0;
      repeat (64) @(negedge CLOCK_50);
      checkOutput("len16_pos15", bus_a.POS, 4'd15);
      checkOutput("len16_nowrap", bus_a.WRAP, 1'b0);
      checkOutput("len16_hex", hex_a, W16_15);
      @(negedge CLOCK_50);
      checkOutput("len16_wrap_pos", bus_a.POS, 4'd0);
      checkOutput("len16_wrap", bus_a.WRAP, 1'b1);

      // RUN=0 on the same edge as a step wins.
      repeat (3) @(negedge CLOCK_50);
      bus_a.RUN = 1'b0;
      @(negedge CLOCK_50);
      checkOutput("run0_priority_pos", bus_a.POS, 4'd0);

      // L=1: every step wraps.
      bus_a.LEN = 5'd1; bus_a.RUN = 1'b1;
      repeat (5) @(negedge CLOCK_50);
      checkOutput("l1_wrap_a", bus_a.WRAP, 1'b1);
      checkOutput("l1_pos", bus_a.POS, 4'd0);
      @(negedge CLOCK_50);
      checkOutput("l1_wrap_pulse", bus_a.WRAP, 1'b0);
      repeat (3) @(negedge CLOCK_50);
      checkOutput("l1_wrap_b", bus_a.WRAP, 1'b1);
      bus_a.RUN = 1'b0;

      // Hold window on the HOLD_TICKS=2 instance.
      bus_b.LEN = 5'd2; bus_b.DIR = 1'b0; bus_b.RUN = 1'b1;
      repeat (9) @(negedge CLOCK_50);
      checkOutput("hold_wrap", bus_b.WRAP, 1'b1);
      checkOutput("hold_wrap_pos", bus_b.POS, 4'd0);
      blanks = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge CLOCK_50);
         if (hex_b == W_ALLB) blanks++;
         checkOutput($sformatf("hold_frozen%0d", j), bus_b.POS, 4'd0);
      end
`ifdef HEX_SCROLL_BLINK_EN
      checkOutput("hold_blank_count", blanks, 4);
`else
      checkOutput("hold_blank_count", blanks, 0);
`endif
      repeat (3) @(negedge CLOCK_50);
      checkOutput("hold_last_pos", bus_b.POS, 4'd0);
      checkOutput("hold_static_hex", hex_b, WL2_0);
      @(negedge CLOCK_50);
      checkOutput("hold_release_pos", bus_b.POS, 4'd1);
      bus_b.RUN = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
